// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM note sequencer.
// A table entry is {period[15:8], duration[7:0]}. A duration of zero is the end marker.
package pwm_seq_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

  localparam int PERIOD_MSB = 15;
  localparam int PERIOD_LSB = 8;
  localparam int DUR_MSB    = 7;
  localparam int DUR_LSB    = 0;

  localparam logic [7:0] END_MARKER_DUR = 8'd0;

  // The duty byte is floor(period/2), which gives roughly 50% duty.
  function automatic logic [15:0] pwm_word(input logic [7:0] period);
    return {period, 1'b0, period[7:1]};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Tempo prescaler. It counts modulo TICK_DIV while en is high.
// tick is asserted on the last count of each period.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt;
  logic         wrap;

  assign wrap = (cnt == W'(TICK_DIV - 1));
  assign tick = en && wrap;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en)
      cnt <= wrap ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/pwm_note_sequencer.sv
// Plays a host-written note table by driving the PWM configuration word.
// Each note holds {P, P>>1} for D ticks, followed by GAP_TICKS silent ticks.
module pwm_note_sequencer
  import pwm_seq_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int TICK_DIV  = 50000,
  parameter  int GAP_TICKS = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  output logic [15:0]   pwm_reg,
  output logic          muted,
  output logic          busy,
  output logic [AW-1:0] note_idx,
  output logic          done
);

  // One counter serves both the note duration and the gap length.
  localparam int CW = (GAP_TICKS > 255) ? $clog2(GAP_TICKS + 1) : 8;

  state_t        state, state_n;
  logic [15:0]   table_q [DEPTH];
  logic [15:0]   entry;
  logic [15:0]   pwm_n;
  logic [AW-1:0] idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          done_n;
  logic          presc_clr;
  logic          tick;

  assign busy  = (state != IDLE);
  assign entry = table_q[note_idx];

  // The table has no reset, so its contents survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (wr_en && !busy)
      table_q[wr_addr] <= wr_data;
  end

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .reset (reset),
    .clr   (presc_clr),
    .en    (state == PLAY || state == GAP),
    .tick  (tick)
  );

  always_comb begin
    state_n   = state;
    pwm_n     = pwm_reg;
    idx_n     = note_idx;
    cnt_n     = cnt;
    done_n    = 1'b0;
    presc_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          idx_n   = '0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (entry[DUR_MSB:DUR_LSB] == END_MARKER_DUR) begin
          // A marker at entry 0 always ends playback, which rules out an empty infinite loop.
          if (loop && note_idx != '0) begin
            idx_n = '0;
          end else begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end else begin
          pwm_n     = pwm_word(entry[PERIOD_MSB:PERIOD_LSB]);
          cnt_n     = CW'(entry[DUR_MSB:DUR_LSB]);
          presc_clr = 1'b1;
          state_n   = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          if (cnt == CW'(1)) begin
            pwm_n     = '0;
            cnt_n     = CW'(GAP_TICKS);
            presc_clr = 1'b1;
            state_n   = GAP;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (cnt != CW'(1)) begin
            cnt_n = cnt - CW'(1);
          end else if (note_idx == AW'(DEPTH - 1)) begin
            if (loop) begin
              idx_n   = '0;
              state_n = FETCH;
            end else begin
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end else begin
            idx_n   = note_idx + AW'(1);
            state_n = FETCH;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // An abort silences the output at once and keeps the current index visible.
    if (stop && state != IDLE) begin
      state_n = IDLE;
      pwm_n   = '0;
      idx_n   = note_idx;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pwm_reg  <= '0;
      muted    <= 1'b1;
      done     <= 1'b0;
      note_idx <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      pwm_reg  <= pwm_n;
      muted    <= (pwm_n == 16'h0);
      done     <= done_n;
      note_idx <= idx_n;
      cnt      <= cnt_n;
    end
  end

endmodule

// File: tb/tb_pwm_note_sequencer.sv
// Scoreboard bench for pwm_note_sequencer.
// A timeline model emits the expected output changes, and a monitor pops them as the DUT changes.
module tb_pwm_note_sequencer;

  localparam int DEPTH = 16;
  localparam int TD    = 4;
  localparam int GAP   = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] pwm_reg;
  logic        muted, busy, done;
  logic [3:0]  note_idx;

  pwm_note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD), .GAP_TICKS(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pwm_reg(pwm_reg), .muted(muted), .busy(busy), .note_idx(note_idx), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] pwm;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         tl[$];
  logic [15:0] mtable [DEPTH];
  logic [21:0] m_prev = '0;
  bit          mon_on = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = data;
    step();
    wr_en = 1'b0;
    mtable[addr] = data;
  endtask

  task automatic push_ev(input int c, input logic [15:0] p, input logic b, input logic d,
                         input logic [3:0] i);
    if ({p, b, d, i} !== m_prev) begin
      exp_q.push_back('{c, p, b, d, i});
      m_prev = {p, b, d, i};
    end
  endtask

  // Per-cycle reference timeline of playback. Entry j describes cycle start+1+j.
  task automatic build(input bit lp, input int maxlen);
    int          idx;
    logic [7:0]  p, d;
    idx = 0;
    tl.delete();
    while (tl.size() < maxlen) begin
      p = mtable[idx][15:8];
      d = mtable[idx][7:0];
      tl.push_back('{0, 16'h0, 1'b1, 1'b0, 4'(idx)});
      if (d == 8'd0) begin
        if (lp && idx != 0) begin
          idx = 0;
          continue;
        end
        tl.push_back('{0, 16'h0, 1'b0, 1'b1, 4'(idx)});
        tl.push_back('{0, 16'h0, 1'b0, 1'b0, 4'(idx)});
        break;
      end
      repeat (int'(d) * TD) tl.push_back('{0, {p, p >> 1}, 1'b1, 1'b0, 4'(idx)});
      repeat (GAP * TD) tl.push_back('{0, 16'h0, 1'b1, 1'b0, 4'(idx)});
      if (idx == DEPTH - 1) begin
        if (lp) idx = 0;
        else begin
          tl.push_back('{0, 16'h0, 1'b0, 1'b1, 4'(idx)});
          tl.push_back('{0, 16'h0, 1'b0, 1'b0, 4'(idx)});
          break;
        end
      end else begin
        idx++;
      end
    end
  endtask

  // abort_k: -1 none, -2 random, else stop/reset is asserted in cycle start+abort_k.
  task automatic run(input bit lp, input int abort_k, input bit abort_rst, input bit wr_busy);
    int t0, k, nb, b;
    build(lp, 400);
    nb = 0;
    while (nb < tl.size() && tl[nb].busy) nb++;
    k = abort_k;
    if (k == -2 || (k == -1 && nb == tl.size())) k = $urandom_range(1, (nb > 150) ? 150 : nb);
    if (k > nb) k = nb;
    loop = lp;
    t0 = cyc;
    for (int j = 0; j < tl.size(); j++) begin
      if (k >= 1 && j >= k) break;
      push_ev(t0 + 1 + j, tl[j].pwm, tl[j].busy, tl[j].done, tl[j].idx);
    end
    if (k >= 1) push_ev(t0 + k + 1, 16'h0, 1'b0, 1'b0, abort_rst ? 4'h0 : tl[k-1].idx);
    start = 1'b1;
    step();
    start = 1'b0;
    if (k >= 1) begin
      while (cyc < t0 + k) step();
      if (abort_rst) reset = 1'b1;
      else stop = 1'b1;
      step();
      reset = 1'b0;
      stop  = 1'b0;
    end else if (wr_busy) begin
      while (cyc < t0 + 3) step();
      wr_en   = 1'b1;
      wr_addr = 4'd0;
      wr_data = 16'h7703;
      step();
      wr_en = 1'b0;
    end
    b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      step();
      b++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout cyc=%0d pending=%0d want=0", cyc, exp_q.size());
      exp_q.delete();
    end
    repeat (4) step();
  endtask

  task automatic basic_table();
    wr(0, 16'h4002);
    wr(1, 16'h2001);
    wr(2, 16'h0000);
  endtask

  initial begin
    fork
      begin : monitor
        logic [21:0] mon_prev, cur;
        ev_t ev;
        mon_prev = '0;
        forever begin
          @(negedge clk);
          if (mon_on) begin
            chk("muted_vs_pwm", 32'(muted), 32'(pwm_reg == 16'h0));
            cur = {pwm_reg, busy, done, note_idx};
            if (cur !== mon_prev) begin
              total++;
              if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change cyc=%0d got pwm=%h busy=%b done=%b idx=%0d want no change",
                         cyc, pwm_reg, busy, done, note_idx);
              end else begin
                ev = exp_q.pop_front();
                if (ev.cyc != cyc || {ev.pwm, ev.busy, ev.done, ev.idx} !== cur) begin
                  bad++;
                  $display("FAIL event got cyc=%0d pwm=%h busy=%b done=%b idx=%0d want cyc=%0d pwm=%h busy=%b done=%b idx=%0d",
                           cyc, pwm_reg, busy, done, note_idx, ev.cyc, ev.pwm, ev.busy, ev.done, ev.idx);
                end
              end
              mon_prev = cur;
            end
          end
        end
      end
    join_none

    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_pwm", 32'(pwm_reg), 32'h0);
    chk("rst_muted", 32'(muted), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_idx", 32'(note_idx), 32'h0);
    for (int i = 0; i < DEPTH; i++) wr(i, 16'h0);
    mon_on = 1'b1;

    basic_table();
    run(1'b0, -1, 1'b0, 1'b0);
    run(1'b1, 60, 1'b0, 1'b0);

    wr(0, 16'h4101);
    for (int i = 1; i < DEPTH; i++) wr(i, {8'($urandom), 8'h01});
    run(1'b0, -1, 1'b0, 1'b0);

    wr(0, 16'h0000);
    run(1'b1, -1, 1'b0, 1'b0);

    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) step();
    chk("startstop_idle_busy", 32'(busy), 32'h0);
    chk("startstop_idle_pwm", 32'(pwm_reg), 32'h0);

    basic_table();
    run(1'b0, -1, 1'b0, 1'b1);
    run(1'b0, -1, 1'b0, 1'b0);
    run(1'b0, 5, 1'b1, 1'b0);
    run(1'b0, -1, 1'b0, 1'b0);

    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < DEPTH; i++)
        wr(i, {8'($urandom), ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 3))});
      run(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? -2 : -1,
          1'($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
